// File: rtl/jk_reg_bank.sv
// Bank of WIDTH independent JK-style bits driven by 2-bit per-bit commands,
// with a registered change flag and a saturating count of toggle events.
module jk_reg_bank #(
  parameter int unsigned             WIDTH   = 8,
  parameter int unsigned             CNT_W   = 8,
  parameter logic [WIDTH-1:0]        RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*WIDTH-1:0]   state,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic                 changed,
  output logic [CNT_W-1:0]     toggle_cnt
);

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_e;

  logic [WIDTH-1:0] r_q;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic             w_tog_any;
  logic             w_cnt_sat;

  // With en low the bank holds, so w_q_next == r_q and the change flag drops.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
    w_q_next  = r_q;
    w_tog_any = 1'b0;
    if (en) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        case (cmd_e'(state[2*i +: 2]))
          CMD_HOLD:   w_q_next[i] = r_q[i];
          CMD_RESET:  w_q_next[i] = 1'b0;
          CMD_SET:    w_q_next[i] = 1'b1;
          CMD_TOGGLE: begin
            w_q_next[i] = ~r_q[i];
            w_tog_any   = 1'b1;
          end
          default:    w_q_next[i] = r_q[i];
        endcase
      end
    end
  end

  assign w_cnt_sat = &r_cnt;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_q       <= RST_VAL;
      r_changed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= (w_q_next != r_q);
      // Clear beats a coincident toggle event; the count never wraps.
      if (cnt_clr)
        r_cnt <= '0;
      else if (w_tog_any && !w_cnt_sat)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign q          = r_q;
  assign qn         = ~r_q;
  assign changed    = r_changed;
  assign toggle_cnt = r_cnt;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: three instances (default, 2-bit counter,
// non-zero reset value) share one stimulus stream; expectations are hand-computed.
module tb_jk_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] state;
  logic        cnt_clr;

  logic [7:0] a_q, a_qn, a_cnt;
  logic       a_chg;
  logic [7:0] b_q, b_qn;
  logic [1:0] b_cnt;
  logic       b_chg;
  logic [7:0] c_q, c_qn, c_cnt;
  logic       c_chg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(8), .CNT_W(8), .RST_VAL(8'h00)) dut_a (
    .clk(clk), .rst(rst), .en(en), .state(state), .cnt_clr(cnt_clr),
    .q(a_q), .qn(a_qn), .changed(a_chg), .toggle_cnt(a_cnt));

  jk_reg_bank #(.WIDTH(8), .CNT_W(2), .RST_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .en(en), .state(state), .cnt_clr(cnt_clr),
    .q(b_q), .qn(b_qn), .changed(b_chg), .toggle_cnt(b_cnt));

  jk_reg_bank #(.WIDTH(8), .CNT_W(8), .RST_VAL(8'h3C)) dut_c (
    .clk(clk), .rst(rst), .en(en), .state(state), .cnt_clr(cnt_clr),
    .q(c_q), .qn(c_qn), .changed(c_chg), .toggle_cnt(c_cnt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] eq, input logic ech, input logic [7:0] ecnt);
    check({tag, ".q"},   {24'h0, a_q},   {24'h0, eq});
    check({tag, ".qn"},  {24'h0, a_qn},  {24'h0, ~eq});
    check({tag, ".chg"}, {31'h0, a_chg}, {31'h0, ech});
    check({tag, ".cnt"}, {24'h0, a_cnt}, {24'h0, ecnt});
  endtask

  task automatic chk_b(input string tag, input logic [7:0] eq, input logic [1:0] ecnt);
    check({tag, ".q"},   {24'h0, b_q},   {24'h0, eq});
    check({tag, ".qn"},  {24'h0, b_qn},  {24'h0, ~eq});
    check({tag, ".cnt"}, {30'h0, b_cnt}, {30'h0, ecnt});
  endtask

  task automatic chk_c(input string tag, input logic [7:0] eq, input logic ech, input logic [7:0] ecnt);
    check({tag, ".q"},   {24'h0, c_q},   {24'h0, eq});
    check({tag, ".qn"},  {24'h0, c_qn},  {24'h0, ~eq});
    check({tag, ".chg"}, {31'h0, c_chg}, {31'h0, ech});
    check({tag, ".cnt"}, {24'h0, c_cnt}, {24'h0, ecnt});
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; state = 16'h0000; cnt_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_a("rst_a", 8'h00, 1'b0, 8'd0);
    chk_c("rst_c", 8'h3C, 1'b0, 8'd0);

    // All SET then HOLD
    en = 1'b1; state = 16'hAAAA; step();
    chk_a("set_all", 8'hFF, 1'b1, 8'd0);
    state = 16'h0000; step();
    chk_a("hold", 8'hFF, 1'b0, 8'd0);

    // All RESET, then mixed SET/RESET/TOGGLE/HOLD
    state = 16'h5555; step();
    chk_a("reset_all", 8'h00, 1'b1, 8'd0);
    state = 16'h0036; step();
    chk_a("mixed", 8'h05, 1'b1, 8'd1);

    // Toggle stream, then disabled bank ignores commands
    do_reset();
    en = 1'b1; state = 16'hFFFF;
    step(); chk_a("tog1", 8'hFF, 1'b1, 8'd1);
    step(); chk_a("tog2", 8'h00, 1'b1, 8'd2);
    step(); chk_a("tog3", 8'hFF, 1'b1, 8'd3);
    en = 1'b0;
    step(); chk_a("dis1", 8'hFF, 1'b0, 8'd3);
    step(); chk_a("dis2", 8'hFF, 1'b0, 8'd3);

    // Saturation on the 2-bit counter
    do_reset();
    en = 1'b1; state = 16'hFFFF;
    step(); chk_b("sat1", 8'hFF, 2'd1);
    step(); chk_b("sat2", 8'h00, 2'd2);
    step(); chk_b("sat3", 8'hFF, 2'd3);
    step(); chk_b("sat4", 8'h00, 2'd3);
    step(); chk_b("sat5", 8'hFF, 2'd3);
    // Clear wins over a coincident toggle; q still toggles
    cnt_clr = 1'b1; step(); chk_b("clr_tog", 8'h00, 2'd0);
    cnt_clr = 1'b0; step(); chk_b("after_clr", 8'hFF, 2'd1);
    // Clear honoured while disabled
    en = 1'b0; cnt_clr = 1'b1; step(); chk_b("clr_dis", 8'hFF, 2'd0);
    check("clr_dis.chg", {31'h0, b_chg}, 32'h0);
    cnt_clr = 1'b0;

    // Reset mid-stream with non-zero reset value
    do_reset();
    en = 1'b1; state = 16'hFFFF;
    step(); chk_c("c_tog1", 8'hC3, 1'b1, 8'd1);
    step(); chk_c("c_tog2", 8'h3C, 1'b1, 8'd2);
    step(); chk_c("c_tog3", 8'hC3, 1'b1, 8'd3);
    rst = 1'b1; cnt_clr = 1'b1; step();
    chk_c("c_rst", 8'h3C, 1'b0, 8'd0);
    rst = 1'b0; cnt_clr = 1'b0; step();
    chk_c("c_resume", 8'hC3, 1'b1, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of JK bits in the bank (>=1).
REQ-002 Parameter CNT_W, default 8: width of toggle-event counter (>=1).
REQ-003 Parameter RST_VAL, default {WIDTH{1'b0}}: q value loaded on reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  bank enable; 0 = all bits hold.
REQ-007 state  input  2*WIDTH  per-bit command; bit i uses state[2i+1:2i]; 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
REQ-008 cnt_clr  input  1  synchronous clear of toggle_cnt.
REQ-009 q  output  WIDTH  registered bank value.
REQ-010 qn  output  WIDTH  always bitwise complement of q.
REQ-011 changed  output  1  registered flag: q changed on the most recent edge.
REQ-012 toggle_cnt  output  CNT_W  saturating count of toggle events.

Function
REQ-013 Each edge with rst=0, en=1: bit i next = q[i] (HOLD), 0 (RESET), 1 (SET), ~q[i] (TOGGLE); all bits independent, same edge.
REQ-014 Edge with rst=0, en=0: q, toggle_cnt hold regardless of state; changed <= 0.
REQ-015 Latency: command sampled at edge k appears on q immediately after edge k (one register stage, no combinational path state->q).
REQ-016 qn is derived from registered q; qn == ~q in every cycle, including reset cycle.
REQ-017 changed <= (q_next != q) on each non-reset edge; high exactly one cycle per changing edge, concurrent with new q.
REQ-018 Toggle event: edge with rst=0, en=1 and at least one bit commanded 11; toggle_cnt increments by 1 per event (not per bit).
REQ-019 toggle_cnt saturates at 2^CNT_W-1; further events leave it unchanged, no wrap.
REQ-020 cnt_clr=1 (rst=0): toggle_cnt <= 0 at that edge; clear wins over simultaneous toggle event; q logic unaffected by cnt_clr.
REQ-021 cnt_clr is honoured when en=0.

Reset
REQ-022 rst=1 at an edge: q <= RST_VAL, qn = ~RST_VAL, changed <= 0, toggle_cnt <= 0.
REQ-023 rst has priority over en, state, cnt_clr; reset mid-sequence discards the command of that edge.
REQ-024 No asynchronous behaviour; rst sampled only at rising clk.

Verification
REQ-025 (WIDTH=8, RST_VAL=0) rst=1 one edge -> q=0x00, qn=0xFF, changed=0, toggle_cnt=0.
REQ-026 en=1, state=0xAAAA one edge, then 0x0000 -> q=0xFF with changed=1, then q=0xFF with changed=0.
REQ-027 From q=0x00, en=1, state=0x0036 (bit0 SET, bit1 RESET, bit2 TOGGLE, rest HOLD) -> q=0x05, changed=1, toggle_cnt=1.
REQ-028 From q=0x00, state=0xFFFF three edges -> q=0xFF,0x00,0xFF; toggle_cnt=3; then en=0 with 0xFFFF two edges -> q=0xFF, toggle_cnt=3, changed=0.
REQ-029 CNT_W=2: five toggle edges -> toggle_cnt=1,2,3,3,3; cnt_clr=1 with toggle same edge -> toggle_cnt=0, q still toggles.
REQ-030 rst=1 asserted during toggle stream with RST_VAL=0x3C -> next cycle q=0x3C, qn=0xC3, toggle_cnt=0, changed=0; toggling resumes the edge after rst falls.
